// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    // Access sequencing: accept in IDLE, count wait states, then respond
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;

    // Number of word-index bits for an array of depth_words entries
    function automatic int idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/dmem_wait_ctr.sv
// rtl/dmem_wait_ctr.sv - 4-bit load/decrement wait-state counter
module dmem_wait_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Load takes priority; decrement saturates at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 4'd0);

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data memory with wait states (optional DMEM_BYTE_STROBE_EN)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] rd,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int IDX_W  = idx_width(DEPTH_WORDS);
    localparam int HI_LSB = IDX_W + ADDR_LSB;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [31:0] mem [0:DEPTH_WORDS-1];

    dmem_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             oor_q, oor_d;
    logic             wr_q, wr_d;
    logic [31:0]      wd_q, wd_d;
    logic [31:0]      rd_q, rd_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]       be_q, be_d;
`endif

    logic             req_rd, req_wr, req_ok;
    logic [IDX_W-1:0] req_idx, ld_idx;
    logic             req_oor, req_mis, ld_oor, ld_is_read;
    logic             ctr_load, ctr_dec, ctr_zero, enter_resp, mem_we;

    assign req_rd  = MemRead & ~MemWrite;
    assign req_wr  = MemWrite & ~MemRead;
    assign req_ok  = req_rd | req_wr;
    assign req_idx = addr[HI_LSB-1:ADDR_LSB];
    assign req_oor = |addr[31:HI_LSB];
    assign req_mis = |addr[ADDR_LSB-1:0];

    // With zero wait states RESP is entered straight from IDLE, before the request is latched
    assign ld_idx     = (state_q == ST_IDLE) ? req_idx : idx_q;
    assign ld_oor     = (state_q == ST_IDLE) ? req_oor : oor_q;
    assign ld_is_read = (state_q == ST_IDLE) ? req_rd  : ~wr_q;

    dmem_wait_ctr u_wait_ctr (
        .clk      (clk),
        .rst_n    (rst),
        .load     (ctr_load),
        .load_val (WAIT_INIT),
        .dec      (ctr_dec),
        .zero     (ctr_zero)
    );

    // Next-state, request latching, load data and sticky error
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        oor_d      = oor_q;
        wr_d       = wr_q;
        wd_d       = wd_q;
`ifdef DMEM_BYTE_STROBE_EN
        be_d       = be_q;
`endif
        err_d      = err_q;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemRead && MemWrite) begin
                    err_d = 1'b1;
                end else if (req_ok) begin
                    idx_d = req_idx;
                    oor_d = req_oor;
                    wr_d  = req_wr;
                    wd_d  = wd;
`ifdef DMEM_BYTE_STROBE_EN
                    be_d  = be;
`endif
                    if (req_mis || req_oor) begin
                        err_d = 1'b1;
                    end
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d  = ST_WAIT;
                        ctr_load = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (ctr_zero) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rd_d = rd_q;
        if (enter_resp && ld_is_read) begin
            rd_d = ld_oor ? 32'd0 : mem[ld_idx];
        end
        done_d = enter_resp;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            wr_q    <= 1'b0;
            wd_q    <= 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= 4'd0;
`endif
            rd_q    <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            wr_q    <= wr_d;
            wd_q    <= wd_d;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= be_d;
`endif
            rd_q    <= rd_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Stores commit on the edge leaving RESP; out-of-range stores are dropped
    assign mem_we = (state_q == ST_RESP) && wr_q && !oor_q;

    // Array write port, never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
`ifdef DMEM_BYTE_STROBE_EN
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
                end
            end
`else
            mem[idx_q] <= wd_q;
`endif
        end
    end

    assign stall = ((state_q == ST_IDLE) && req_ok) || (state_q == ST_WAIT);
    assign rd    = rd_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule
